// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter with bounded lock in front of DataMemory
// Registered read return with a one-cycle rvalid strobe per requester.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LP_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } fsm_t;

  fsm_t                  r_fsm;
  fsm_t                  w_fsm_nxt;
  logic                  r_prio;
  logic                  w_prio_nxt;
  logic [CW-1:0]         r_lock_cnt;
  logic [CW-1:0]         w_lock_cnt_nxt;
  logic [CW-1:0]         w_cnt_inc;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_m0_rvalid;
  logic                  r_m1_rvalid;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_rd0;
  logic                  w_rd1;

  assign w_cnt_inc = r_lock_cnt + 1'b1;
  assign w_rd0     = w_gnt0 & ~m0_we;
  assign w_rd1     = w_gnt1 & ~m1_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_prio      <= 1'b0;
      r_lock_cnt  <= '0;
      r_rdata     <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_prio      <= w_prio_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_m0_rvalid <= w_rd0;
      r_m1_rvalid <= w_rd1;
      if (w_rd0 | w_rd1) begin
        r_rdata <= mem_data_out;
      end
    end
  end

  // Leaving a lock tenure (release, bubble or forced timeout) always favours the other side.
  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_prio_nxt     = r_prio;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_fsm)
      S_IDLE: begin
        if (w_gnt0) begin
          w_prio_nxt = 1'b1;
          if (m0_lock) begin
            w_fsm_nxt      = S_LOCK0;
            w_lock_cnt_nxt = CW'(1);
          end
        end else if (w_gnt1) begin
          w_prio_nxt = 1'b0;
          if (m1_lock) begin
            w_fsm_nxt      = S_LOCK1;
            w_lock_cnt_nxt = CW'(1);
          end
        end
      end
      S_LOCK0: begin
        w_lock_cnt_nxt = w_cnt_inc;
        if (!(m0_req && m0_lock && (w_cnt_inc < LP_MAX))) begin
          w_fsm_nxt      = S_IDLE;
          w_prio_nxt     = 1'b1;
          w_lock_cnt_nxt = '0;
        end
      end
      S_LOCK1: begin
        w_lock_cnt_nxt = w_cnt_inc;
        if (!(m1_req && m1_lock && (w_cnt_inc < LP_MAX))) begin
          w_fsm_nxt      = S_IDLE;
          w_prio_nxt     = 1'b0;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_fsm_nxt      = S_IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    if (!rst) begin
      case (r_fsm)
        S_IDLE: begin
          if (m0_req && (!m1_req || !r_prio)) begin
            w_gnt0 = 1'b1;
          end else if (m1_req) begin
            w_gnt1 = 1'b1;
          end
        end
        S_LOCK0: w_gnt0 = m0_req;
        S_LOCK1: w_gnt1 = m1_req;
        default: ;
      endcase
    end
    if (w_gnt0) begin
      mem_we      = m0_we;
      mem_re      = ~m0_we;
      mem_addr    = m0_addr;
      mem_data_in = m0_wdata;
    end else if (w_gnt1) begin
      mem_we      = m1_we;
      mem_re      = ~m1_we;
      mem_addr    = m1_addr;
      mem_data_in = m1_wdata;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a DataMemory stand-in
// Stimulus pushes predicted grants and read returns; two monitors pop and compare.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int ML = 8;

  logic          clk, rst;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory stand-in: combinational read, write at posedge
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  logic          mem_init;
  assign mem_data_out = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data_in;
    end
  end

  typedef struct packed {
    logic          g0, g1, we, re;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } gnt_t;
  typedef struct packed {
    logic          v0, v1;
    logic [DW-1:0] d;
  } rd_t;

  gnt_t q_gnt[$];
  rd_t  q_rd[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: who holds the memory, how many grants in this tenure, who wins a tie
  int            m_holder, m_tenure, m_fav;
  logic [DW-1:0] m_rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_tenure = 0;
    m_fav    = 0;
    m_rdata  = '0;
  endtask

  task automatic cyc(input logic r0, w0, l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, w1, l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int   pick, x;
    logic lk;
    gnt_t g;
    rd_t  r;
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    pick = -1;
    if (m_holder < 0) begin
      if (r0 && r1) pick = m_fav;
      else if (r0) pick = 0;
      else if (r1) pick = 1;
      if (pick >= 0) begin
        m_fav = 1 - pick;
        lk = (pick == 0) ? l0 : l1;
        if (lk) begin
          m_holder = pick;
          m_tenure = 1;
        end
      end
    end else begin
      x = m_holder;
      if ((x == 0) ? r0 : r1) begin
        pick = x;
        m_tenure++;
        lk = (x == 0) ? l0 : l1;
        if (!(lk && m_tenure < ML)) begin
          m_holder = -1;
          m_fav = 1 - x;
        end
      end else begin
        m_holder = -1;
        m_fav = 1 - x;
      end
    end
    g = '0;
    r = '0;
    if (pick == 0) begin
      g.g0 = 1'b1; g.we = w0; g.re = ~w0; g.addr = a0; g.din = d0;
    end else if (pick == 1) begin
      g.g1 = 1'b1; g.we = w1; g.re = ~w1; g.addr = a1; g.din = d1;
    end
    if (pick >= 0) begin
      if (g.we) ref_mem[g.addr] = g.din;
      else m_rdata = ref_mem[g.addr];
    end
    r.v0 = g.g0 & g.re;
    r.v1 = g.g1 & g.re;
    r.d  = m_rdata;
    q_gnt.push_back(g);
    q_rd.push_back(r);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  always begin
    gnt_t e;
    @(negedge clk);
    #2;
    if (q_gnt.size() > 0) begin
      e = q_gnt.pop_front();
      chk("grant/mem drive", 64'({m0_gnt, m1_gnt, mem_we, mem_re, mem_addr, mem_data_in}), 64'(e));
    end
  end

  always begin
    rd_t e;
    @(posedge clk);
    #1;
    if (q_rd.size() > 0) begin
      e = q_rd.pop_front();
      chk("rvalid/rdata", 64'({m0_rvalid, m1_rvalid, rdata}), 64'(e));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lk_pct;
    logic r0, r1;
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    mem_init = 1'b1;
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    @(posedge clk);
    #2;
    chk("reset gnt", 64'({m0_gnt, m1_gnt}), 64'(0));
    chk("reset mem_we/re", 64'({mem_we, mem_re}), 64'(0));
    chk("reset rdata", 64'(rdata), 64'(0));
    chk("reset rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(0));
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    model_reset();

    // first grant after reset goes to m0
    cyc(1, 0, 0, 4'd1, '0, 1, 0, 0, 4'd2, '0);
    // single write then read
    cyc(1, 1, 0, 4'd3, 32'hDEADBEEF, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 4'd3, '0, 0, 0, 0, '0, '0);
    idle_cyc();
    // contention: both reading every cycle
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 4'(i), '0, 1, 0, 0, 4'(i + 8), '0);
    // lock RMW by m1 on addr 5
    cyc(1, 0, 0, 4'd0, '0, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 4'd1, '0, 1, 0, 1, 4'd5, '0);
    cyc(1, 0, 0, 4'd1, '0, 1, 1, 0, 4'd5, 32'h0BADF00D);
    cyc(1, 0, 0, 4'd5, '0, 0, 0, 0, '0, '0);
    idle_cyc();
    // lock timeout: m0 holds lock indefinitely while m1 waits
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 4'(i), '0, 1, 0, 0, 4'd7, '0);
    idle_cyc();
    // randomized traffic with varying lock pressure
    for (int seg = 0; seg < 6; seg++) begin
      lk_pct = (seg % 2 == 0) ? 15 : 85;
      for (int i = 0; i < 100; i++) begin
        r0 = ($urandom_range(0, 99) < 70);
        r1 = ($urandom_range(0, 99) < 70);
        cyc(r0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < lk_pct), 4'($urandom), $urandom,
            r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < lk_pct), 4'($urandom), $urandom);
      end
    end
    idle_cyc();
    idle_cyc();

    // reset during LOCK0 with a read granted: rvalid must be dropped
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b1; m0_addr = 4'd2; m1_req = 1'b0;
    @(negedge clk);
    m0_addr = 4'd4;
    #2;
    rst = 1'b1;
    #1;
    chk("mid-lock reset gnt", 64'({m0_gnt, m1_gnt, mem_re, mem_we}), 64'(0));
    @(posedge clk);
    #1;
    chk("mid-lock reset rvalid/rdata", 64'({m0_rvalid, m1_rvalid, rdata}), 64'(0));
    @(negedge clk);
    rst = 1'b0; m0_req = 1'b0; m0_lock = 1'b0;
    model_reset();
    cyc(1, 0, 0, 4'd6, '0, 1, 0, 0, 4'd9, '0);
    cyc(1, 0, 0, 4'd6, '0, 1, 0, 0, 4'd9, '0);
    idle_cyc();

    for (int i = 0; i < 10 && (q_gnt.size() > 0 || q_rd.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 64'(q_gnt.size() + q_rd.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
